// File: rtl/if_id_hazard_stage.sv
// rtl/if_id_hazard_stage.sv - IF/ID pipeline register with load-use hazard detection and flush control
module if_id_hazard_stage #(
  parameter int          XLEN      = 64,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [31:0]      instr_in,
  input  logic             fetch_valid,
  input  logic             flush,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_rd,
  output logic [XLEN-1:0]  pc_out,
  output logic [31:0]      instr_out,
  output logic             valid_out,
  output logic [4:0]       rs1_out,
  output logic [4:0]       rs2_out,
  output logic [4:0]       rd_out,
  output logic             bubble,
  output logic             pc_write,
  output logic             fetch_ready,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]  pc_q;
  logic [31:0]      instr_q;
  logic             valid_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             hazard;
  logic             stall;

  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;
  assign rs1_out   = instr_q[19:15];
  assign rs2_out   = instr_q[24:20];
  assign rd_out    = instr_q[11:7];

  // Both source fields are compared unconditionally; a false stall on an
  // instruction that ignores rs2 costs one cycle and saves a decoder here.
  assign hazard = valid_q & idex_MemRead & (idex_rd != 5'd0) &
                  ((idex_rd == rs1_out) | (idex_rd == rs2_out));
  assign stall  = hazard & ~flush;

  assign bubble      = flush | hazard | ~valid_q;
  assign pc_write    = ~stall;
  assign fetch_ready = ~stall;

  assign stall_count = stall_q;
  assign flush_count = flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (flush) begin
      pc_q    <= pc_in;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!stall) begin
      pc_q    <= pc_in;
      instr_q <= fetch_valid ? instr_in : NOP_INSTR;
      valid_q <= fetch_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && (stall_q != CNT_MAX)) stall_q <= stall_q + CNT_ONE;
      if (flush && (flush_q != CNT_MAX)) flush_q <= flush_q + CNT_ONE;
    end
  end

endmodule
